// File: rtl/truth_table_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker: state encoding,
// sweep geometry and the default expected masks for the 4-in/2-out function.
package truth_table_sweep_checker_pkg;

  localparam int MINTERMS = 16;
  localparam int VEC_W    = 4;
  localparam int ERR_W    = 5;

  // Default function under test: Y1 = minterms 4,5,6,7,11,12,13; Y2 = 1,2,4,5.
  localparam logic [15:0] DEF_Y1_MASK = 16'h38F0;
  localparam logic [15:0] DEF_Y2_MASK = 16'h0036;
  localparam int          DEF_SETTLE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // True when either observed output disagrees with its mask bit for this minterm.
  function automatic logic minterm_mismatch(
    input logic [15:0] y1_mask,
    input logic [15:0] y2_mask,
    input logic [3:0]  idx,
    input logic        y1,
    input logic        y2
  );
    return (y1 != y1_mask[idx]) || (y2 != y2_mask[idx]);
  endfunction

endpackage

// File: rtl/truth_table_sweep_checker_settle_timer.sv
// Loadable down-counter used to hold each minterm for the settle time.
// expire is high during the last enabled cycle (count has reached zero).
module truth_table_sweep_checker_settle_timer (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       expire
);

  logic [3:0] count;

  // Count register: load has priority, then decrement while enabled, stop at zero.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end else begin
      count <= count;
    end
  end

  assign expire = en && (count == 4'd0);

endmodule

// File: rtl/truth_table_sweep_checker.sv
// Synthesizable sweep driver/checker for 4-input, 2-output combinational blocks.
// Drives {A,B,C,D} through minterms 0..15, holds each for SETTLE cycles,
// samples Y1_in/Y2_in for one cycle and counts minterms that disagree with
// Y1_MASK/Y2_MASK. SETTLE legal range is 1..15.
// Optional build macro STOP_ON_FAIL_EN: the first mismatch ends the sweep.
module truth_table_sweep_checker
  import truth_table_sweep_checker_pkg::*;
#(
  parameter logic [15:0] Y1_MASK = DEF_Y1_MASK,
  parameter logic [15:0] Y2_MASK = DEF_Y2_MASK,
  parameter int          SETTLE  = DEF_SETTLE
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  input  logic             Y1_in,
  input  logic             Y2_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_idx,
  output logic             first_fail_valid
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(MINTERMS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] vec_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [VEC_W-1:0] ffi_nxt;
  logic             ffv_nxt;
  logic             done_nxt;
  logic             busy_nxt;
  logic             pass_nxt;
  logic             mismatch;
  logic             last_vec;
  logic             timer_load;
  logic             timer_en;
  logic             timer_expire;

  // Outputs only count in the SAMPLE cycle; elsewhere they are ignored.
  assign mismatch = (state == ST_SAMPLE) &&
                    minterm_mismatch(Y1_MASK, Y2_MASK, vec, Y1_in, Y2_in);
  assign last_vec = (vec == LAST_VEC);

  // Reload the timer on every entry into SETTLE (from IDLE, DONE or SAMPLE).
  assign timer_load = (state_nxt == ST_SETTLE) && (state != ST_SETTLE);
  assign timer_en   = (state == ST_SETTLE);

  truth_table_sweep_checker_settle_timer u_settle_timer (
    .clock    (clock),
    .reset_b  (reset_b),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .en       (timer_en),
    .expire   (timer_expire)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start is only honoured when no sweep is running.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (timer_expire) begin
          state_nxt = ST_SAMPLE;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
`ifdef STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
        end
`else
        if (last_vec) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
        end
`endif
      end
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered status and vector outputs.
  always_comb begin
    vec_nxt  = vec;
    err_nxt  = err_count;
    ffi_nxt  = first_fail_idx;
    ffv_nxt  = first_fail_valid;
    done_nxt = done;
    busy_nxt = busy;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_nxt  = {VEC_W{1'b0}};
          err_nxt  = {ERR_W{1'b0}};
          ffv_nxt  = 1'b0;
          done_nxt = 1'b0;
          busy_nxt = 1'b1;
        end else begin
          busy_nxt = 1'b0;
        end
      end
      ST_SETTLE: begin
        busy_nxt = 1'b1;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_nxt = err_count + 5'd1;
          if (!first_fail_valid) begin
            ffi_nxt = vec;
            ffv_nxt = 1'b1;
          end else begin
            ffv_nxt = 1'b1;
          end
        end else begin
          err_nxt = err_count;
        end
        if (state_nxt == ST_DONE) begin
          vec_nxt  = {VEC_W{1'b0}};
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end else begin
          vec_nxt  = vec + 4'd1;
          busy_nxt = 1'b1;
        end
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
    pass_nxt = done_nxt && (err_nxt == 5'd0);
  end

  // Output registers: all status outputs and the driven vector come from flops.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      vec              <= {VEC_W{1'b0}};
      err_count        <= {ERR_W{1'b0}};
      first_fail_idx   <= {VEC_W{1'b0}};
      first_fail_valid <= 1'b0;
      done             <= 1'b0;
      busy             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      vec              <= vec_nxt;
      err_count        <= err_nxt;
      first_fail_idx   <= ffi_nxt;
      first_fail_valid <= ffv_nxt;
      done             <= done_nxt;
      busy             <= busy_nxt;
      pass             <= pass_nxt;
    end
  end

  assign A = vec[3];
  assign B = vec[2];
  assign C = vec[1];
  assign D = vec[0];

endmodule
